// File: rtl/sram_sp_masked_init.sv
// rtl/sram_sp_masked_init.sv - parametrised single-port SRAM model with per-bit write mask and zero-init sweep
// Optional output register stage (2-cycle read latency): define SRAM_OUT_REG_EN.
module sram_sp_masked_init #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] BWEB,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  RVALID,
  output logic                  INIT_DONE,
  output logic                  ADDR_ERR
);

  if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_depth
    $error("sram_sp_masked_init: 2**ADDR_WIDTH must be >= DEPTH");
  end

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the range compare
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    rvalid_q, rvalid_d;
  logic                    addr_err_q, addr_err_d;

  logic [DATA_WIDTH-1:0]   ram_q [DEPTH];

  logic                    in_range;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   wr_keep;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign in_range = ({1'b0, A} < DEPTH_EXT);
  assign rd_word  = in_range ? ram_q[A] : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    rvalid_d   = 1'b0;
    addr_err_d = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = cnt_q;
    wr_data    = '0;
    wr_keep    = '0;

    case (state_q)
      ST_INIT: begin
        // Sweep clears one word per cycle; port inputs are ignored here
        wr_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (!CEB) begin
          if (!in_range) begin
            addr_err_d = 1'b1;
            if (WEB) begin
              q_d      = '0;
              rvalid_d = 1'b1;
            end
          end else if (!WEB) begin
            wr_en   = 1'b1;
            wr_idx  = A;
            wr_data = D;
            wr_keep = BWEB;
          end else begin
            q_d      = rd_word;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      q_q        <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array is deliberately not reset; the sweep is what clears it
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      ram_q[wr_idx] <= (ram_q[wr_idx] & wr_keep) | (wr_data & ~wr_keep);
    end
  end

  assign INIT_DONE = (state_q == ST_READY);

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q2_q, q2_d;
  logic                  rvalid2_q, rvalid2_d;
  logic                  addr_err2_q, addr_err2_d;

  always_comb begin
    q2_d        = rvalid_q ? q_q : q2_q;
    rvalid2_d   = rvalid_q;
    addr_err2_d = addr_err_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q2_q        <= '0;
      rvalid2_q   <= 1'b0;
      addr_err2_q <= 1'b0;
    end else begin
      q2_q        <= q2_d;
      rvalid2_q   <= rvalid2_d;
      addr_err2_q <= addr_err2_d;
    end
  end

  assign Q        = q2_q;
  assign RVALID   = rvalid2_q;
  assign ADDR_ERR = addr_err2_q;
`else
  assign Q        = q_q;
  assign RVALID   = rvalid_q;
  assign ADDR_ERR = addr_err_q;
`endif

endmodule

// File: tb/tb_sram_sp_masked_init.sv
// tb/tb_sram_sp_masked_init.sv - directed bench for sram_sp_masked_init (16-deep and 12-deep instances)
module tb_sram_sp_masked_init;

  logic         clk;
  logic         rst;
  logic         ceb;
  logic         web;
  logic [3:0]   a;
  logic [127:0] d;
  logic [127:0] bweb;

  logic [127:0] q16, q12;
  logic         rv16, rv12, id16, id12, ae16, ae12;

  int n_cmp;
  int n_err;

  sram_sp_masked_init #(.DATA_WIDTH(128), .DEPTH(16), .ADDR_WIDTH(4)) u_dut16 (
    .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
    .Q(q16), .RVALID(rv16), .INIT_DONE(id16), .ADDR_ERR(ae16)
  );

  sram_sp_masked_init #(.DATA_WIDTH(128), .DEPTH(12), .ADDR_WIDTH(4)) u_dut12 (
    .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
    .Q(q12), .RVALID(rv12), .INIT_DONE(id12), .ADDR_ERR(ae12)
  );

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [3:0] aa,
                       input logic [127:0] dd, input logic [127:0] bb);
    ceb  = c;
    web  = w;
    a    = aa;
    d    = dd;
    bweb = bb;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'd0, '0, '1);
  endtask

  task automatic wait_lat();
`ifdef SRAM_OUT_REG_EN
    @(negedge clk);
`endif
  endtask

  task automatic wr(input logic [3:0] aa, input logic [127:0] dd, input logic [127:0] bb);
    drive(1'b0, 1'b0, aa, dd, bb);
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [3:0] aa);
    drive(1'b0, 1'b1, aa, '0, '1);
    @(negedge clk);
    idle();
    wait_lat();
  endtask

  logic [127:0] ones;
  logic [127:0] masked;
  logic [127:0] bw_lo;
  logic [127:0] exp_seq [3];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ones   = '1;
    bw_lo  = ~128'hFF;
    masked = {{120{1'b1}}, 8'h00};
    exp_seq[0] = 128'hA;
    exp_seq[1] = 128'hB;
    exp_seq[2] = 128'hC;

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_q", q16, '0);
    chk("rst_rvalid", rv16, 0);
    chk("rst_init_done", id16, 0);
    chk("rst_addr_err", ae16, 0);

    // Sweep: junk write presented throughout must be ignored by the 16-deep instance
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd3, ones, '0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sweep16_done_%0d", i), id16, 0);
      chk($sformatf("sweep12_done_%0d", i), id12, (i >= 12));
      chk($sformatf("sweep16_rvalid_%0d", i), rv16, 0);
      chk($sformatf("sweep16_aerr_%0d", i), ae16, 0);
      @(negedge clk);
    end
    idle();
    chk("sweep16_done_final", id16, 1);

    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("init_rd_q_%0d", i), q16, '0);
      chk($sformatf("init_rd_rv_%0d", i), rv16, 1);
    end
    @(negedge clk);
    chk("idle_rvalid_drop", rv16, 0);

    // Full write, then masked write clearing only the low byte
    wr(4'd3, ones, '0);
    wait_lat();
    chk("wr_no_rvalid", rv16, 0);
    chk("wr_q_hold", q16, '0);
    rd(4'd3);
    chk("full_wr_q", q16, ones);
    wr(4'd3, '0, bw_lo);
    rd(4'd3);
    chk("mask_wr_q", q16, masked);
    wr(4'd3, '0, '1);
    rd(4'd3);
    chk("noop_wr_q", q16, masked);

    // Out-of-range on the 12-deep instance
    rd(4'd3);
    chk("d12_rd3", q12, masked);
    wr(4'd13, 128'h1234, '0);
    wait_lat();
    chk("d12_oor_wr_aerr", ae12, 1);
    chk("d12_oor_wr_rv", rv12, 0);
    chk("d16_inrange_wr_aerr", ae16, 0);
    @(negedge clk);
    chk("d12_aerr_pulse_end", ae12, 0);
    rd(4'd13);
    chk("d12_oor_rd_q", q12, '0);
    chk("d12_oor_rd_rv", rv12, 1);
    chk("d12_oor_rd_aerr", ae12, 1);
    chk("d16_rd13_q", q16, 128'h1234);
    chk("d16_rd13_aerr", ae16, 0);
    rd(4'd5);
    chk("d12_no_alias", q12, '0);
    wr(4'd11, 128'hBB, '0);
    rd(4'd11);
    chk("d12_last_q", q12, 128'hBB);
    chk("d12_last_aerr", ae12, 0);
    rd(4'd12);
    chk("d12_edge_q", q12, '0);
    chk("d12_edge_aerr", ae12, 1);

    // Back-to-back reads then idle hold
    wr(4'd0, 128'hA, '0);
    wr(4'd1, 128'hB, '0);
    wr(4'd2, 128'hC, '0);
    for (int j = 0; j < 6; j++) begin
      if (j < 3) drive(1'b0, 1'b1, 4'(j), '0, '1);
      else idle();
      @(negedge clk);
      if ((j + 1) >= LAT && (j + 1) <= LAT + 2) begin
        chk($sformatf("b2b_q_%0d", j), q16, exp_seq[j + 1 - LAT]);
        chk($sformatf("b2b_rv_%0d", j), rv16, 1);
      end else if ((j + 1) == LAT + 3) begin
        chk("b2b_hold_q", q16, 128'hC);
        chk("b2b_hold_rv", rv16, 0);
      end
    end

    // Read immediately after write to the same address
    drive(1'b0, 1'b0, 4'd7, 128'h77, '0);
    @(negedge clk);
    rd(4'd7);
    chk("raw_q", q16, 128'h77);
    chk("raw_rv", rv16, 1);

    // Reset mid-sweep restarts it and clears previously written data
    wr(4'd12, 128'hDEAD, '0);
    rd(4'd12);
    chk("pre_rst_q", q16, 128'hDEAD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_q", q16, '0);
    repeat (8) @(negedge clk);
    chk("mid_sweep_done", id16, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("restart_done_15", id16, 0);
    @(negedge clk);
    chk("restart_done_16", id16, 1);
    rd(4'd12);
    chk("post_rst_ram12", q16, '0);
    chk("post_rst_rv", rv16, 1);

    // Read latency alignment of Q and RVALID
    wr(4'd5, 128'h55, '0);
    drive(1'b0, 1'b1, 4'd5, '0, '1);
    @(negedge clk);
    idle();
`ifdef SRAM_OUT_REG_EN
    chk("lat_n1_q", q16, '0);
    chk("lat_n1_rv", rv16, 0);
    @(negedge clk);
    chk("lat_n2_q", q16, 128'h55);
    chk("lat_n2_rv", rv16, 1);
`else
    chk("lat_n1_q", q16, 128'h55);
    chk("lat_n1_rv", rv16, 1);
    @(negedge clk);
    chk("lat_n2_q", q16, 128'h55);
    chk("lat_n2_rv", rv16, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
